unidade_busca: RTL and testbench

Instruction-fetch sequencer sitting directly downstream of the 8-bit program counter register. It reads the current PC value and issues a request/acknowledge read to instruction memory. It holds the returned word in an instruction register, offered to decode through a valid/ready handshake. It drives the PC register's write enable (`esc_pc`) and next value (`pc_prox`), either PC+1 after a successful fetch or a branch target on redirect.

---
 rtl/busca_pkg.sv | 15 +
 rtl/unidade_busca.sv | 114 +++++++++++
 tb/tb_unidade_busca.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package busca_pkg;

  localparam int PC_W        = 8;
  localparam int INSTR_W_DEF = 16;
  localparam logic [PC_W-1:0] PC_RESET = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } estado_busca_t;

endpackage

// File: rtl/unidade_busca.sv
// Instruction-fetch sequencer: reads the PC, fetches one word from memory by
// req/ack, and offers it to decode through instr_valid/instr_ready.
module unidade_busca #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_atual,
  output logic               esc_pc,
  output logic [PC_W-1:0]    pc_prox,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               desvio,
  input  logic [PC_W-1:0]    desvio_alvo
);
  import busca_pkg::*;

  // Handshakes: mem_req/mem_addr stay stable until the cycle mem_ack is seen;
  // instr transfers to decode in a cycle where instr_valid and instr_ready are both 1.

  estado_busca_t      estado_q, estado_d;
  logic               mem_req_q, mem_req_d;
  logic [PC_W-1:0]    mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               descarte_q, descarte_d;
  logic               incrementa;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q      <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= PC_W'(PC_RESET);
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      descarte_q    <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      descarte_q    <= descarte_d;
    end
  end

  always_comb begin
    estado_d      = estado_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    descarte_d    = descarte_q;
    incrementa    = 1'b0;

    case (estado_q)
      IDLE: estado_d = ISSUE;

      ISSUE: begin
        // A redirect here means pc_atual is stale; retry next cycle with the new PC.
        if (!desvio) begin
          mem_addr_d = pc_atual;
          mem_req_d  = 1'b1;
          estado_d   = WAIT;
        end
      end

      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (desvio || descarte_q) begin
            descarte_d = 1'b0;
            estado_d   = ISSUE;
          end else begin
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
            incrementa    = 1'b1;
            estado_d      = HOLD;
          end
        end else if (desvio) begin
          // The in-flight read belongs to the old path; let it finish, then drop it.
          descarte_d = 1'b1;
        end
      end

      HOLD: begin
        if (desvio || instr_ready) begin
          instr_valid_d = 1'b0;
          estado_d      = ISSUE;
        end
      end

      default: estado_d = IDLE;
    endcase
  end

  // Redirect wins over the post-fetch increment; increment wraps modulo 2^PC_W.
  always_comb begin
    esc_pc  = (desvio | incrementa) & ~reset;
    pc_prox = desvio ? desvio_alvo : mem_addr_q + PC_W'(1);
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca: reset, fetch, backpressure, wrap-around,
// redirects in each state, and reset during an outstanding request.
module tb_unidade_busca;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [PC_W-1:0]    pc_atual;
  logic               esc_pc;
  logic [PC_W-1:0]    pc_prox;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               desvio;
  logic [PC_W-1:0]    desvio_alvo;

  int n_tests = 0;
  int n_fail  = 0;
  int esc_cnt = 0;
  int esc_base;

  unidade_busca #(.INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_atual   (pc_atual),
    .esc_pc     (esc_pc),
    .pc_prox    (pc_prox),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .desvio     (desvio),
    .desvio_alvo(desvio_alvo)
  );

  // clock / reset
  always #5 clk = ~clk;

  // counts PC writes actually taken at a clock edge
  always @(posedge clk) begin
    if (!reset && esc_pc) esc_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    pc_atual    = 8'h00;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    desvio      = 1'b1;
    desvio_alvo = 8'h77;
    #1;
    // reset values; redirect must not write the PC while reset is held
    check("rst_esc_pc", 32'(esc_pc), 32'd0);
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    desvio = 1'b0;
    tick();
    reset = 1'b0;

    // first fetch: IDLE -> ISSUE -> WAIT
    tick();
    check("f1_req_issue", 32'(mem_req), 32'd0);
    tick();
    check("f1_req", 32'(mem_req), 32'd1);
    check("f1_addr", 32'(mem_addr), 32'h00);
    check("f1_esc_wait", 32'(esc_pc), 32'd0);
    tick();
    check("f1_req_hold", 32'(mem_req), 32'd1);
    esc_base  = esc_cnt;
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    #1;
    check("f1_esc_ack", 32'(esc_pc), 32'd1);
    check("f1_pc_prox", 32'(pc_prox), 32'h01);
    check("f1_valid_ack", 32'(instr_valid), 32'd0);
    tick();
    mem_ack  = 1'b0;
    pc_atual = 8'h01;
    check("f1_valid", 32'(instr_valid), 32'd1);
    check("f1_instr", 32'(instr), 32'h1234);
    check("f1_req_off", 32'(mem_req), 32'd0);

    // backpressure: five cycles of instr_ready=0
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", 32'(instr), 32'h1234);
      check("bp_req", 32'(mem_req), 32'd0);
      check("bp_esc", 32'(esc_pc), 32'd0);
      tick();
    end
    check("bp_one_write", 32'(esc_cnt - esc_base), 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_valid_off", 32'(instr_valid), 32'd0);

    // wrap-around at 0xFF, immediate ack
    pc_atual = 8'hFF;
    tick();
    check("wr_addr", 32'(mem_addr), 32'hFF);
    mem_ack   = 1'b1;
    mem_rdata = 16'hABCD;
    #1;
    check("wr_esc", 32'(esc_pc), 32'd1);
    check("wr_pc_prox", 32'(pc_prox), 32'h00);
    tick();
    mem_ack = 1'b0;
    check("wr_instr", 32'(instr), 32'hABCD);
    check("wr_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // redirect during WAIT, ack three cycles later
    pc_atual = 8'h05;
    tick();
    check("rw_addr", 32'(mem_addr), 32'h05);
    esc_base    = esc_cnt;
    desvio      = 1'b1;
    desvio_alvo = 8'h40;
    #1;
    check("rw_esc", 32'(esc_pc), 32'd1);
    check("rw_pc_prox", 32'(pc_prox), 32'h40);
    tick();
    desvio = 1'b0;
    #1;
    check("rw_esc_off", 32'(esc_pc), 32'd0);
    check("rw_req_kept", 32'(mem_req), 32'd1);
    check("rw_addr_kept", 32'(mem_addr), 32'h05);
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    check("rw_esc_ack", 32'(esc_pc), 32'd0);
    tick();
    mem_ack  = 1'b0;
    pc_atual = 8'h40;
    check("rw_valid", 32'(instr_valid), 32'd0);
    check("rw_req_off", 32'(mem_req), 32'd0);
    check("rw_one_write", 32'(esc_cnt - esc_base), 32'd1);
    tick();
    check("rw_new_addr", 32'(mem_addr), 32'h40);
    check("rw_new_req", 32'(mem_req), 32'd1);

    // redirect coincident with ack
    esc_base    = esc_cnt;
    mem_ack     = 1'b1;
    mem_rdata   = 16'hBEEF;
    desvio      = 1'b1;
    desvio_alvo = 8'h10;
    #1;
    check("rc_esc", 32'(esc_pc), 32'd1);
    check("rc_pc_prox", 32'(pc_prox), 32'h10);
    tick();
    mem_ack  = 1'b0;
    desvio   = 1'b0;
    pc_atual = 8'h10;
    check("rc_valid", 32'(instr_valid), 32'd0);
    check("rc_instr", 32'(instr), 32'hABCD);
    check("rc_req_off", 32'(mem_req), 32'd0);
    check("rc_one_write", 32'(esc_cnt - esc_base), 32'd1);

    // redirect while holding an instruction
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("rh_valid", 32'(instr_valid), 32'd1);
    desvio      = 1'b1;
    desvio_alvo = 8'h80;
    #1;
    check("rh_pc_prox", 32'(pc_prox), 32'h80);
    tick();
    desvio = 1'b0;
    check("rh_valid_off", 32'(instr_valid), 32'd0);

    // redirect in ISSUE suppresses the request
    desvio      = 1'b1;
    desvio_alvo = 8'h22;
    tick();
    desvio   = 1'b0;
    pc_atual = 8'h22;
    check("ri_no_req", 32'(mem_req), 32'd0);
    tick();
    check("ri_req", 32'(mem_req), 32'd1);
    check("ri_addr", 32'(mem_addr), 32'h22);

    // asynchronous reset during WAIT
    #2;
    reset = 1'b1;
    #1;
    check("ra_req", 32'(mem_req), 32'd0);
    check("ra_valid", 32'(instr_valid), 32'd0);
    check("ra_addr", 32'(mem_addr), 32'h00);
    tick();
    reset    = 1'b0;
    pc_atual = 8'h00;
    tick();
    check("ra_issue_req", 32'(mem_req), 32'd0);
    tick();
    check("ra_restart_req", 32'(mem_req), 32'd1);
    check("ra_restart_addr", 32'(mem_addr), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
